// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// Grants one operation at a time (IDLE -> EXEC -> DONE), holds the result
// until the consumer takes it, and alternates priority between requesters.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               ptr;      // requester that wins a tie
    logic               gnt0, gnt1;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic               id_q, err_q;
    logic               op_illegal;

    // Codes above SUB (3'b100) are not defined for the ALU.
    assign op_illegal = (op_q > 3'd4);

    // Next-state and grant decode; grants only exist in IDLE.
    always_comb begin
        state_d = state;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !ptr)) gnt0 = 1'b1;
                else if (req1_valid)                     gnt1 = 1'b1;
                if (gnt0 || gnt1) state_d = EXEC;
            end
            EXEC:    state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Readies are forced low while reset is asserted so nothing is
    // handed off during an edge that will discard it anyway.
    assign req0_ready = gnt0 && !rst;
    assign req1_ready = gnt1 && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Operand capture on grant, result capture in EXEC, pointer flip on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= 1'b0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                op_q <= gnt1 ? req1_op : req0_op;
                a_q  <= gnt1 ? req1_a  : req0_a;
                b_q  <= gnt1 ? req1_b  : req0_b;
                id_q <= gnt1;
            end
            if (state == EXEC) begin
                res_q <= op_illegal ? '0 : alu_out;
                err_q <= op_illegal;
            end
            if (state == DONE && rsp_ready) ptr <= ~id_q;
        end
    end

    // ALU inputs always come from the latched operands, so they stay
    // steady between operations instead of following the request buses.
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_q;
    assign rsp_data  = res_q;
    assign rsp_err   = err_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Inputs change on the falling edge; outputs
// are sampled just after the falling edge, well away from the rising edge.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Shared ALU model; illegal codes return a non-zero pattern so the
    // block's zeroing of illegal results is visible.
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a & alu_b;
            3'd1:    alu_out = alu_a | alu_b;
            3'd2:    alu_out = alu_a ^ alu_b;
            3'd3:    alu_out = alu_a + alu_b;
            3'd4:    alu_out = alu_a - alu_b;
            default: alu_out = 32'hDEADBEEF;
        endcase
    end

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd2; req0_a = 32'h1234_5678; req0_b = 32'h1;
        req1_op = 3'd3; req1_a = 32'h5;         req1_b = 32'h6;
        @(negedge clk); @(negedge clk); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        checks++; if ({rsp_valid, rsp_id, rsp_err, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {rsp_valid, rsp_id, rsp_err, busy}); end
        checks++; if ({alu_op, alu_a, alu_b, rsp_data} !== '0) begin errors++; $display("FAIL reset_regs op=%h a=%h b=%h d=%h exp=0", alu_op, alu_a, alu_b, rsp_data); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Single XOR request from req0 with rsp_ready high.
    task automatic test_xor();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'hFFDF1F40; req0_b = 32'h80031F4F;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL xor_grant got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk); req0_valid = 1'b0; #1;
        checks++; if ({busy, rsp_valid, req0_ready} !== 3'b100) begin errors++; $display("FAIL xor_exec busy/valid/rdy got=%b exp=100", {busy, rsp_valid, req0_ready}); end
        checks++; if (alu_a !== 32'hFFDF1F40 || alu_b !== 32'h80031F4F || alu_op !== 3'd2) begin errors++; $display("FAIL xor_alu_in a=%h b=%h op=%0d", alu_a, alu_b, alu_op); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100 || rsp_data !== 32'h7FDC000F) begin errors++; $display("FAIL xor_rsp v/id/err=%b data=%h exp=100 7fdc000f", {rsp_valid, rsp_id, rsp_err}, rsp_data); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL xor_idle got=%b exp=00", {rsp_valid, busy}); end
    endtask

    // Simultaneous requests right after reset: req0 first, then req1, then req0 again.
    task automatic test_arb();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'hFFFFFFFF; req0_b = 32'h0000FFFF;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'h00000000; req1_b = 32'h80000000;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL arb_first got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk); req0_valid = 1'b0; #1;
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL arb_exec_rdy1 got=%b exp=0", req1_ready); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_data !== 32'h0000FFFF || req1_ready !== 1'b0) begin errors++; $display("FAIL arb_rsp0 v/id=%b data=%h rdy1=%b exp=10 0000ffff 0", {rsp_valid, rsp_id}, rsp_data, req1_ready); end
        @(negedge clk); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL arb_second got=%b exp=01", {req0_ready, req1_ready}); end
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id} !== 2'b11 || rsp_data !== 32'h80000000) begin errors++; $display("FAIL arb_rsp1 v/id=%b data=%h exp=11 80000000", {rsp_valid, rsp_id}, rsp_data); end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL arb_third got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    // req1 ADD with the consumer stalled for 5 cycles; carry is discarded.
    task automatic test_stall();
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'hFFFFFFFF; req1_b = 32'h00000001;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL stall_grant got=%b exp=01", {req0_ready, req1_ready}); end
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h1; req0_b = 32'h2;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL stall_exec_rdy0 got=%b exp=0", req0_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if ({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready} !== 5'b11000 || rsp_data !== 32'h0) begin errors++; $display("FAIL stall_hold cyc=%0d v/id/err/r0/r1=%b data=%h exp=11000 0", i, {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}, rsp_data); end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, req0_ready} !== 2'b01) begin errors++; $display("FAIL stall_release v/r0=%b exp=01", {rsp_valid, req0_ready}); end
        req0_valid = 1'b0;
    endtask

    // Illegal op code: zero data, error flag, same two-cycle latency.
    task automatic test_illegal();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd7; req0_a = 32'h12345678; req0_b = 32'h1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ill_grant got=%b exp=1", req0_ready); end
        @(negedge clk); req0_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_early got=%b exp=0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b101 || rsp_data !== 32'h0) begin errors++; $display("FAIL ill_rsp v/id/err=%b data=%h exp=101 0", {rsp_valid, rsp_id, rsp_err}, rsp_data); end
    endtask

    // Reset lands while req1 SUB is executing; pointer was 1 beforehand.
    task automatic test_reset_exec();
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'h10; req1_b = 32'h3;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rexec_grant got=%b exp=1", req1_ready); end
        @(negedge clk); req1_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if ({rsp_valid, busy, rsp_id} !== 3'b000 || rsp_data !== 32'h0 || alu_a !== 32'h0) begin errors++; $display("FAIL rexec_clear v/busy/id=%b data=%h a=%h exp=000 0 0", {rsp_valid, busy, rsp_id}, rsp_data, alu_a); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rexec_norsp got=%b exp=00", {rsp_valid, busy}); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rexec_ptr got=%b exp=10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Both valid continuously: 12 grants alternating 0,1,... every 3 cycles.
    task automatic test_back_to_back();
        int grants;
        logic exp_id;
        grants = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'h0F0F0F0F; req0_b = 32'h00FF00FF;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'h7FFFFFFF; req1_b = 32'h00000001;
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_id = ((k / 3) % 2) != 0;
            if (req0_ready || req1_ready) grants++;
            checks++;
            if (req0_ready !== ((k % 3 == 0) && !exp_id) || req1_ready !== ((k % 3 == 0) && exp_id)) begin
                errors++; $display("FAIL b2b_grant k=%0d r0/r1=%b%b", k, req0_ready, req1_ready);
            end
            if (k % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== (exp_id ? 32'h80000000 : 32'h0FF00FF0)) begin
                    errors++; $display("FAIL b2b_rsp k=%0d v=%b id=%b data=%h exp_id=%b", k, rsp_valid, rsp_id, rsp_data, exp_id);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (grants != 12) begin errors++; $display("FAIL b2b_count got=%0d exp=12", grants); end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_arb();
        test_stall();
        test_illegal();
        test_reset_exec();
        test_back_to_back();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
